// File: rtl/pipelined_controller.sv
// pipelined_controller
//   Control path for the 5-stage RISC-V pipeline. Decodes the IF/ID
//   instruction in the D stage. Control then moves through the ID/EX, EX/MEM
//   and MEM/WB registers. The branch/jump redirect is resolved in E from the
//   ALU flags.
//
//   Optional feature: define CTRL_ILLEGAL_TRAP_EN to add the illegal_e
//   output. It is a registered flag for an unrecognised opcode or an
//   unsupported R-type encoding.
//
//   Parameters
//     ALUC_W      ALU control code width (>= 4)
//     FUNC3_PIPE  1: mem_size_m = funct3 of the M instruction; 0: fixed 3'b010
//
//   Ports
//     clk, rst                 clock, synchronous active-low reset
//     op_d/func3_d/func7_d     instruction fields from IF/ID
//     flush_e                  load a NOP bubble into ID/EX
//     zero_e/lt_e/ltu_e        ALU flags for the instruction in E
//     imm_src_d                immediate format (combinational)
//     alu_src_e, alu_ctrl_e    ALU operand select / operation
//     jalr_e, pc_src_e         redirect target select / take redirect
//     load_e                   E instruction is a load
//     reg_write_m, mem_write_m, mem_size_m
//     reg_write_w, result_src_w
//     illegal_e                (CTRL_ILLEGAL_TRAP_EN only)
module pipelined_controller #(
   parameter int ALUC_W     = 4,
   parameter bit FUNC3_PIPE = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [6:0]        op_d,
   input  logic [2:0]        func3_d,
   input  logic [6:0]        func7_d,
   input  logic              flush_e,
   input  logic              zero_e,
   input  logic              lt_e,
   input  logic              ltu_e,
   output logic [2:0]        imm_src_d,
   output logic              alu_src_e,
   output logic [ALUC_W-1:0] alu_ctrl_e,
   output logic              jalr_e,
   output logic              pc_src_e,
   output logic              load_e,
   output logic              reg_write_m,
   output logic              mem_write_m,
   output logic [2:0]        mem_size_m,
   output logic              reg_write_w,
   output logic [1:0]        result_src_w
`ifdef CTRL_ILLEGAL_TRAP_EN
   ,
   output logic              illegal_e
`endif
);

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_STORE= 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   localparam logic [ALUC_W-1:0] ALU_AND  = ALUC_W'(4'b0000);
   localparam logic [ALUC_W-1:0] ALU_OR   = ALUC_W'(4'b0001);
   localparam logic [ALUC_W-1:0] ALU_ADD  = ALUC_W'(4'b0010);
   localparam logic [ALUC_W-1:0] ALU_XOR  = ALUC_W'(4'b0011);
   localparam logic [ALUC_W-1:0] ALU_SLT  = ALUC_W'(4'b0100);
   localparam logic [ALUC_W-1:0] ALU_SLTU = ALUC_W'(4'b0101);
   localparam logic [ALUC_W-1:0] ALU_SUB  = ALUC_W'(4'b0110);
   localparam logic [ALUC_W-1:0] ALU_SLL  = ALUC_W'(4'b0111);
   localparam logic [ALUC_W-1:0] ALU_SRL  = ALUC_W'(4'b1000);
   localparam logic [ALUC_W-1:0] ALU_SRA  = ALUC_W'(4'b1001);

   typedef struct packed {
      logic              reg_write;
      logic [1:0]        result_src;
      logic              mem_write;
      logic              jump;
      logic              branch;
      logic              alu_src;
      logic              jalr;
      logic              load;
      logic [2:0]        func3;
      logic [ALUC_W-1:0] alu_ctrl;
   } ctrl_t;

   ctrl_t      dec;
   ctrl_t      bubble;
   ctrl_t      id_ex;
   logic       r_ok;
   logic       cond;
   logic       reg_write_m_q;
   logic       mem_write_m_q;
   logic [1:0] result_src_m;
   logic [2:0] func3_m;
   logic       reg_write_w_q;
   logic [1:0] result_src_w_q;

   // Supported R-type encodings: every funct3 with funct7=0, or SUB/SRA with funct7[5].
   assign r_ok = (func7_d == 7'b0000000) ||
                 (func7_d == 7'b0100000 && (func3_d == 3'b000 || func3_d == 3'b101));

   always_comb begin
      bubble          = '0;
      bubble.alu_ctrl = ALU_ADD;
   end

   always_comb begin
      dec          = bubble;
      dec.func3    = func3_d;
      imm_src_d    = 3'b000;
      case (op_d)
         OP_R: begin
            if (r_ok) begin
               dec.reg_write = 1'b1;
               case (func3_d)
                  3'b000:  dec.alu_ctrl = func7_d[5] ? ALU_SUB : ALU_ADD;
                  3'b001:  dec.alu_ctrl = ALU_SLL;
                  3'b010:  dec.alu_ctrl = ALU_SLT;
                  3'b011:  dec.alu_ctrl = ALU_SLTU;
                  3'b100:  dec.alu_ctrl = ALU_XOR;
                  3'b101:  dec.alu_ctrl = func7_d[5] ? ALU_SRA : ALU_SRL;
                  3'b110:  dec.alu_ctrl = ALU_OR;
                  default: dec.alu_ctrl = ALU_AND;
               endcase
            end
         end
         OP_I: begin
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            case (func3_d)
               3'b000:  dec.alu_ctrl = ALU_ADD;
               3'b001:  dec.alu_ctrl = ALU_SLL;
               3'b010:  dec.alu_ctrl = ALU_SLT;
               3'b011:  dec.alu_ctrl = ALU_SLTU;
               3'b100:  dec.alu_ctrl = ALU_XOR;
               3'b101:  dec.alu_ctrl = func7_d[5] ? ALU_SRA : ALU_SRL;
               3'b110:  dec.alu_ctrl = ALU_OR;
               default: dec.alu_ctrl = ALU_AND;
            endcase
         end
         OP_LOAD: begin
            dec.alu_src    = 1'b1;
            dec.result_src = 2'b01;
            dec.reg_write  = 1'b1;
            dec.load       = 1'b1;
         end
         OP_STORE: begin
            imm_src_d     = 3'b001;
            dec.alu_src   = 1'b1;
            dec.mem_write = 1'b1;
         end
         OP_BR: begin
            imm_src_d    = 3'b010;
            dec.alu_ctrl = ALU_SUB;
            dec.branch   = 1'b1;
         end
         OP_JAL: begin
            imm_src_d      = 3'b011;
            dec.result_src = 2'b10;
            dec.reg_write  = 1'b1;
            dec.jump       = 1'b1;
         end
         OP_JALR: begin
            dec.jalr       = 1'b1;
            dec.jump       = 1'b1;
            dec.alu_src    = 1'b1;
            dec.result_src = 2'b10;
            dec.reg_write  = 1'b1;
         end
         OP_LUI: begin
            imm_src_d      = 3'b100;
            dec.result_src = 2'b11;
            dec.reg_write  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         id_ex          <= bubble;
         reg_write_m_q  <= 1'b0;
         mem_write_m_q  <= 1'b0;
         result_src_m   <= 2'b00;
         func3_m        <= 3'b000;
         reg_write_w_q  <= 1'b0;
         result_src_w_q <= 2'b00;
      end else begin
         id_ex          <= flush_e ? bubble : dec;
         reg_write_m_q  <= id_ex.reg_write;
         mem_write_m_q  <= id_ex.mem_write;
         result_src_m   <= id_ex.result_src;
         func3_m        <= id_ex.func3;
         reg_write_w_q  <= reg_write_m_q;
         result_src_w_q <= result_src_m;
      end
   end

   always_comb begin
      cond = 1'b0;
      case (id_ex.func3)
         3'b000:  cond = zero_e;
         3'b001:  cond = !zero_e;
         3'b100:  cond = lt_e;
         3'b101:  cond = !lt_e;
         3'b110:  cond = ltu_e;
         3'b111:  cond = !ltu_e;
         default: cond = 1'b0;
      endcase
   end

   assign alu_src_e    = id_ex.alu_src;
   assign alu_ctrl_e   = id_ex.alu_ctrl;
   assign jalr_e       = id_ex.jalr;
   assign load_e       = id_ex.load;
   assign pc_src_e     = id_ex.jump | (id_ex.branch & cond);
   assign reg_write_m  = reg_write_m_q;
   assign mem_write_m  = mem_write_m_q;
   assign mem_size_m   = FUNC3_PIPE ? func3_m : 3'b010;
   assign reg_write_w  = reg_write_w_q;
   assign result_src_w = result_src_w_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
   logic illegal_d;
   logic illegal_q;

   assign illegal_d = !(op_d inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI}) ||
                      (op_d == OP_R && !r_ok);

   always_ff @(posedge clk) begin
      if (!rst || flush_e) illegal_q <= 1'b0;
      else                 illegal_q <= illegal_d;
   end

   assign illegal_e = illegal_q;
`endif

endmodule

// File: tb/tb_pipelined_controller.sv
module tb_pipelined_controller;

   localparam logic [6:0] R   = 7'b0110011;
   localparam logic [6:0] I   = 7'b0010011;
   localparam logic [6:0] L   = 7'b0000011;
   localparam logic [6:0] S   = 7'b0100011;
   localparam logic [6:0] B   = 7'b1100011;
   localparam logic [6:0] JAL = 7'b1101111;
   localparam logic [6:0] JR  = 7'b1100111;
   localparam logic [6:0] LUI = 7'b0110111;
   localparam logic [6:0] BAD = 7'b1111111;
   localparam logic [6:0] F7A = 7'b0100000;

   logic       clk, rst, flush_e, zero_e, lt_e, ltu_e;
   logic [6:0] op_d, func7_d;
   logic [2:0] func3_d, imm_src_d, mem_size_m;
   logic [3:0] alu_ctrl_e;
   logic       alu_src_e, jalr_e, pc_src_e, load_e;
   logic       reg_write_m, mem_write_m, reg_write_w;
   logic [1:0] result_src_w;
`ifdef CTRL_ILLEGAL_TRAP_EN
   logic       illegal_e;
`endif

   pipelined_controller #(.ALUC_W(4), .FUNC3_PIPE(1'b1)) dut (
      .clk(clk), .rst(rst), .op_d(op_d), .func3_d(func3_d), .func7_d(func7_d),
      .flush_e(flush_e), .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
      .imm_src_d(imm_src_d), .alu_src_e(alu_src_e), .alu_ctrl_e(alu_ctrl_e),
      .jalr_e(jalr_e), .pc_src_e(pc_src_e), .load_e(load_e),
      .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .mem_size_m(mem_size_m),
      .reg_write_w(reg_write_w), .result_src_w(result_src_w)
`ifdef CTRL_ILLEGAL_TRAP_EN
      , .illegal_e(illegal_e)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [2:0] flags;   // {zero, lt, ltu} applied while in E
      logic       fl;
      logic [2:0] imm;
      logic [3:0] alu;
      logic       aluchk;
      logic [5:0] ctl;     // {alu_src, jalr, pc_src, load, reg_write, mem_write}
      logic [1:0] rs;
      logic       szchk;
      logic [2:0] sz;
      logic       ill;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;
   vec_t tab[$];
   vec_t q[$];

   task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask

   function automatic vec_t v(string n, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                              logic [2:0] flags, logic fl, logic [2:0] imm, logic [3:0] alu,
                              logic [5:0] ctl, logic [1:0] rs, logic szchk, logic [2:0] sz);
      vec_t r;
      r.name = n; r.op = op; r.f3 = f3; r.f7 = f7; r.flags = flags; r.fl = fl;
      r.imm = imm; r.alu = alu; r.aluchk = 1'b1; r.ctl = ctl; r.rs = rs;
      r.szchk = szchk; r.sz = sz;
      r.ill = !(op inside {R, I, L, S, B, JAL, JR, LUI});
      if (fl) begin
         r.aluchk = 1'b0; r.ctl = '0; r.rs = 2'b00; r.szchk = 1'b0; r.ill = 1'b0;
      end
      return r;
   endfunction

   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      op_d = op; func3_d = f3; func7_d = f7;
   endtask

   task automatic check_cleared(input string n);
      chk({n, "_alu"}, {4'b0, alu_ctrl_e}, 8'h02);
      chk({n, "_asrc"}, {7'b0, alu_src_e}, 8'h00);
      chk({n, "_jalr"}, {7'b0, jalr_e}, 8'h00);
      chk({n, "_pcsrc"}, {7'b0, pc_src_e}, 8'h00);
      chk({n, "_load"}, {7'b0, load_e}, 8'h00);
      chk({n, "_rwm"}, {7'b0, reg_write_m}, 8'h00);
      chk({n, "_mwm"}, {7'b0, mem_write_m}, 8'h00);
      chk({n, "_size"}, {5'b0, mem_size_m}, 8'h00);
      chk({n, "_rww"}, {7'b0, reg_write_w}, 8'h00);
      chk({n, "_rsw"}, {6'b0, result_src_w}, 8'h00);
`ifdef CTRL_ILLEGAL_TRAP_EN
      chk({n, "_ill"}, {7'b0, illegal_e}, 8'h00);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t e, m, w;
      //            name     op   f3      f7     flags  fl imm     alu      ctl        rs   sc sz
      tab.push_back(v("add",  R,   3'b000, 7'd0, 3'b000, 0, 3'b000, 4'b0010, 6'b000010, 2'b00, 0, 3'b000));
      tab.push_back(v("sub",  R,   3'b000, F7A,  3'b000, 0, 3'b000, 4'b0110, 6'b000010, 2'b00, 0, 3'b000));
      tab.push_back(v("sra",  R,   3'b101, F7A,  3'b000, 0, 3'b000, 4'b1001, 6'b000010, 2'b00, 0, 3'b000));
      tab.push_back(v("sltu", R,   3'b011, 7'd0, 3'b000, 0, 3'b000, 4'b0101, 6'b000010, 2'b00, 0, 3'b000));
      tab.push_back(v("xor",  R,   3'b100, 7'd0, 3'b000, 0, 3'b000, 4'b0011, 6'b000010, 2'b00, 0, 3'b000));
      tab.push_back(v("sll",  R,   3'b001, 7'd0, 3'b000, 0, 3'b000, 4'b0111, 6'b000010, 2'b00, 0, 3'b000));
      tab.push_back(v("srl",  R,   3'b101, 7'd0, 3'b000, 0, 3'b000, 4'b1000, 6'b000010, 2'b00, 0, 3'b000));
      tab.push_back(v("or",   R,   3'b110, 7'd0, 3'b000, 0, 3'b000, 4'b0001, 6'b000010, 2'b00, 0, 3'b000));
      tab.push_back(v("and",  R,   3'b111, 7'd0, 3'b000, 0, 3'b000, 4'b0000, 6'b000010, 2'b00, 0, 3'b000));
      tab.push_back(v("srai", I,   3'b101, F7A,  3'b000, 0, 3'b000, 4'b1001, 6'b100010, 2'b00, 0, 3'b000));
      tab.push_back(v("andi", I,   3'b111, 7'd0, 3'b000, 0, 3'b000, 4'b0000, 6'b100010, 2'b00, 0, 3'b000));
      tab.push_back(v("slti", I,   3'b010, 7'd0, 3'b000, 0, 3'b000, 4'b0100, 6'b100010, 2'b00, 0, 3'b000));
      tab.push_back(v("blt",  B,   3'b100, 7'd0, 3'b010, 0, 3'b010, 4'b0110, 6'b001000, 2'b00, 0, 3'b000));
      tab.push_back(v("bge",  B,   3'b101, 7'd0, 3'b010, 0, 3'b010, 4'b0110, 6'b000000, 2'b00, 0, 3'b000));
      tab.push_back(v("bgeu", B,   3'b111, 7'd0, 3'b000, 0, 3'b010, 4'b0110, 6'b001000, 2'b00, 0, 3'b000));
      tab.push_back(v("bne",  B,   3'b001, 7'd0, 3'b100, 0, 3'b010, 4'b0110, 6'b000000, 2'b00, 0, 3'b000));
      tab.push_back(v("beq",  B,   3'b000, 7'd0, 3'b100, 0, 3'b010, 4'b0110, 6'b001000, 2'b00, 0, 3'b000));
      tab.push_back(v("bltu", B,   3'b110, 7'd0, 3'b001, 0, 3'b010, 4'b0110, 6'b001000, 2'b00, 0, 3'b000));
      tab.push_back(v("b010", B,   3'b010, 7'd0, 3'b111, 0, 3'b010, 4'b0110, 6'b000000, 2'b00, 0, 3'b000));
      tab.push_back(v("lw",   L,   3'b010, 7'd0, 3'b000, 0, 3'b000, 4'b0010, 6'b100110, 2'b01, 1, 3'b010));
      tab.push_back(v("bubl", R,   3'b000, 7'd0, 3'b000, 1, 3'b000, 4'b0010, 6'b000000, 2'b00, 0, 3'b000));
      tab.push_back(v("sw",   S,   3'b010, 7'd0, 3'b000, 0, 3'b001, 4'b0010, 6'b100001, 2'b00, 1, 3'b010));
      tab.push_back(v("jal",  JAL, 3'b000, 7'd0, 3'b000, 0, 3'b011, 4'b0010, 6'b001010, 2'b10, 0, 3'b000));
      tab.push_back(v("lb",   L,   3'b000, 7'd0, 3'b000, 0, 3'b000, 4'b0010, 6'b100110, 2'b01, 1, 3'b000));
      tab.push_back(v("lui",  LUI, 3'b000, 7'd0, 3'b000, 0, 3'b100, 4'b0010, 6'b000010, 2'b11, 0, 3'b000));
      tab.push_back(v("jalr", JR,  3'b000, 7'd0, 3'b000, 0, 3'b000, 4'b0010, 6'b111010, 2'b10, 0, 3'b000));
      tab.push_back(v("bad",  BAD, 3'b000, 7'd0, 3'b000, 0, 3'b000, 4'b0010, 6'b000000, 2'b00, 0, 3'b000));
      tab.push_back(v("sh",   S,   3'b001, 7'd0, 3'b000, 0, 3'b001, 4'b0010, 6'b100001, 2'b00, 1, 3'b001));
      tab.push_back(v("nop1", BAD, 3'b000, 7'd0, 3'b000, 0, 3'b000, 4'b0010, 6'b000000, 2'b00, 0, 3'b000));
      tab.push_back(v("nop2", BAD, 3'b000, 7'd0, 3'b000, 0, 3'b000, 4'b0010, 6'b000000, 2'b00, 0, 3'b000));

      // Reset held two cycles with an add in D.
      rst = 1'b0; flush_e = 1'b0; zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;
      drive(R, 3'b000, 7'd0);
      repeat (2) begin
         @(posedge clk); #1;
         check_cleared("rst_hold");
      end
      rst = 1'b1;

      // Table-driven stream through the pipeline.
      foreach (tab[i]) begin
         drive(tab[i].op, tab[i].f3, tab[i].f7);
         flush_e = tab[i].fl;
         q.push_back(tab[i]);
         #1;
         chk({tab[i].name, "_imm"}, {5'b0, imm_src_d}, {5'b0, tab[i].imm});
         @(posedge clk); #1;
         flush_e = 1'b0;
         e = q[q.size()-1];
         {zero_e, lt_e, ltu_e} = e.flags;
         #1;
         if (e.aluchk) chk({e.name, "_alu"}, {4'b0, alu_ctrl_e}, {4'b0, e.alu});
         chk({e.name, "_asrc"}, {7'b0, alu_src_e}, {7'b0, e.ctl[5]});
         chk({e.name, "_jalr"}, {7'b0, jalr_e},    {7'b0, e.ctl[4]});
         chk({e.name, "_pcsrc"},{7'b0, pc_src_e},  {7'b0, e.ctl[3]});
         chk({e.name, "_load"}, {7'b0, load_e},    {7'b0, e.ctl[2]});
`ifdef CTRL_ILLEGAL_TRAP_EN
         chk({e.name, "_ill"},  {7'b0, illegal_e}, {7'b0, e.ill});
`endif
         if (q.size() >= 2) begin
            m = q[q.size()-2];
            chk({m.name, "_rwm"}, {7'b0, reg_write_m}, {7'b0, m.ctl[1]});
            chk({m.name, "_mwm"}, {7'b0, mem_write_m}, {7'b0, m.ctl[0]});
            if (m.szchk) chk({m.name, "_size"}, {5'b0, mem_size_m}, {5'b0, m.sz});
         end
         if (q.size() >= 3) begin
            w = q.pop_front();
            chk({w.name, "_rww"}, {7'b0, reg_write_w},  {7'b0, w.ctl[1]});
            chk({w.name, "_rsw"}, {6'b0, result_src_w}, {6'b0, w.rs});
         end
      end
      q.delete();
      {zero_e, lt_e, ltu_e} = 3'b000;

      // jalr in E, then reset and flush together.
      drive(JR, 3'b000, 7'd0);
      @(posedge clk); #1;
      chk("jalr_pre_pcsrc", {7'b0, pc_src_e}, 8'h01);
      drive(R, 3'b000, 7'd0);
      rst = 1'b0; flush_e = 1'b1;
      @(posedge clk); #1;
      flush_e = 1'b0;
      check_cleared("rst_flush");
      @(posedge clk); #1;
      check_cleared("rst_flush2");

      // After release, one add reaches W exactly three edges later.
      rst = 1'b1;
      drive(R, 3'b000, 7'd0);
      @(posedge clk); #1;
      chk("lat_e1_rww", {7'b0, reg_write_w}, 8'h00);
      drive(BAD, 3'b000, 7'd0);
      @(posedge clk); #1;
      chk("lat_e2_rwm", {7'b0, reg_write_m}, 8'h01);
      chk("lat_e2_rww", {7'b0, reg_write_w}, 8'h00);
      @(posedge clk); #1;
      chk("lat_e3_rww", {7'b0, reg_write_w}, 8'h01);
      @(posedge clk); #1;
      chk("lat_e4_rww", {7'b0, reg_write_w}, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pipelined_controller.md
Name: pipelined_controller

Overview:
- Parametrised successor to the single-stage decode controller, for the 5-stage RISC-V pipeline.
- Decodes the instruction held in the IF/ID register, combinationally in the D stage.
- Carries control through internal ID/EX, EX/MEM and MEM/WB registers.
- Resolves branch/jump redirect in EX from ALU flags, and supports hazard-unit bubble insertion.
- Extends the ISA subset: full B-type compare set, XOR/shift/SLTU ALU ops, load/store size tracking.

Parameters:
- ALUC_W, 4, width of ALU control code; must be >= 4.
- FUNC3_PIPE, 1, 1 = carry func3 to MEM as mem_size_m; 0 = mem_size_m tied to 3'b010.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- op_d  in  7  opcode from IF/ID.
- func3_d  in  3  funct3 from IF/ID.
- func7_d  in  7  funct7 from IF/ID.
- flush_e  in  1  load bubble into ID/EX (load-use stall or taken redirect).
- zero_e  in  1  ALU result == 0.
- lt_e  in  1  signed A<B.
- ltu_e  in  1  unsigned A<B.
- imm_src_d  out  3  immediate format (combinational, D stage).
- alu_src_e  out  1  ALU B = immediate.
- alu_ctrl_e  out  ALUC_W  ALU operation.
- jalr_e  out  1  redirect target = ALU result.
- pc_src_e  out  1  take redirect (combinational from E regs + flags).
- load_e  out  1  E-stage instruction is a load (hazard unit).
- reg_write_m  out  1  forwarding qualifier.
- mem_write_m  out  1  data memory write enable.
- mem_size_m  out  3  funct3 of load/store.
- reg_write_w  out  1  register-file write enable.
- result_src_w  out  2  00 ALU, 01 mem, 10 PC+4, 11 imm.

Behaviour:
- Decode is combinational on op_d/func3_d/func7_d; defaults are all 0 except ALU op ADD.
- imm_src codes: I=000, S=001, B=010, J=011, U=100.
- ALU codes (zero-extended to ALUC_W): AND 0000, OR 0001, ADD 0010, XOR 0011, SLT 0100, SLTU 0101, SUB 0110, SLL 0111, SRL 1000, SRA 1001.
- R-type: {func7[5],func3} selects the op; unsupported func7 -> ADD.
- I-ALU: func3 selects the op; SRAI when func7[5]=1. alu_src=1, reg_write=1.
- Load: alu_src=1, result_src=01, reg_write=1.
- Store: imm_src=001, alu_src=1, mem_write=1.
- JAL: imm_src=011, result_src=10, reg_write=1, jump=1.
- JALR: jalr=1, jump=1, alu_src=1, result_src=10, reg_write=1.
- LUI: imm_src=100, result_src=11, reg_write=1.
- Branch: imm_src=010, ALU op SUB; func3 latched into ID/EX.
- Branch condition in E, by func3: 000 zero_e; 001 !zero_e; 100 lt_e; 101 !lt_e; 110 ltu_e; 111 !ltu_e; 010/011 never taken.
- pc_src_e = jump_e | (branch_e & cond).
- Latency:
  - ID->E 1 cycle, E->M 1 cycle, M->W 1 cycle.
  - One instruction enters per clock; no internal stall.
  - IF/ID hold is the hazard unit's job.
- flush_e=1 at an edge: ID/EX loads all-zero control (NOP bubble). EX/MEM and MEM/WB advance normally that edge.
- Unrecognised opcode: decodes as NOP (all write/jump/branch enables 0).
- Reset (rst=0 at edge): all three stage registers cleared, whatever flush_e is; reset wins over flush.
  - All registered outputs read 0 on the following cycle, except alu_ctrl_e = ADD.
  - Hence pc_src_e=0.
- Reset mid-stream discards every in-flight instruction; no partial commit.
- mem_size_m follows func3 of the instruction now in M; for non-memory ops it is don't-care but deterministic.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output illegal_e (1 bit): registered flag set in ID/EX for an unrecognised opcode or unsupported R-type func7/func3.
  - The instruction is still squashed to NOP.
  - illegal_e is cleared by flush_e and by reset.
- Undefined: port absent; illegal encodings decode silently as NOP.

Test Plan:
- Reset: hold rst=0 for 2 cycles while driving add -> all outputs 0 (alu_ctrl_e=0010) in the cycle after the reset edge. Release, then add -> reg_write_w=1 exactly 3 edges later.
- R-type sweep: sub (func7=0100000, func3=000) -> alu_ctrl_e=0110. sra (0100000/101) -> 1001. sltu (0000000/011) -> 0101. Each appears one cycle after decode.
- Branches with sub: blt with lt_e=1 -> pc_src_e=1. bge with lt_e=1 -> 0. bgeu with ltu_e=0 -> 1. bne with zero_e=1 -> 0.
- Load-use: lw, then flush_e=1 on the next edge with add in D -> load_e=1 for one cycle, then 0. Bubble reaches W with reg_write_w=0; lw reaches W with result_src_w=01.
- Store then jal back-to-back -> mem_write_m=1 and mem_size_m=010 for sw. jal: pc_src_e=1 in E, result_src_w=10, reg_write_w=1.
- Simultaneous rst=0 and flush_e=1 mid-stream, with a jalr in E -> all stages cleared, pc_src_e=0 next cycle. (CTRL_ILLEGAL_TRAP_EN builds: illegal_e=0.)
